// File: rtl/card_game_pkg.sv
// Shared types and constants for the ten-and-a-half game engine.
// All scores are carried in half-point (hp) units.
package card_game_pkg;

    localparam int HP_W = 6;

    localparam logic [HP_W-1:0] BUST_HP         = 6'd21;
    localparam logic [HP_W-1:0] DEALER_STAND_HP = 6'd14;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEAL      = 3'd1,
        TURN      = 3'd2,
        WAIT_CARD = 3'd3,
        SETTLE    = 3'd4,
        SHOW      = 3'd5,
        DONE      = 3'd6
    } state_t;

    // Number cards score double their face; face cards and out-of-range codes score a half point.
    function automatic logic [HP_W-1:0] card_hp(input logic [3:0] n);
        if (n >= 4'd1 && n <= 4'd10) return {1'b0, n, 1'b0};
        else                         return 6'd1;
    endfunction

endpackage

// File: rtl/card_game_if.sv
// Card-source handshake: card_req is held while a card is wanted, a card
// transfers on the clock edge where card_req and card_vld are both high.
interface card_game_if;
    logic       card_req;
    logic       card_vld;
    logic [3:0] card_num;

    modport master (output card_req, input card_vld, input card_num);
    modport slave  (input card_req, output card_vld, output card_num);
endinterface

// File: rtl/card_game_ctrl_hand_accum.sv
// One seat's hand: card count, last card taken and running half-point total.
module hand_accum
    import card_game_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            add,
    input  logic [3:0]      card,
    output logic [2:0]      cnt,
    output logic [3:0]      last,
    output logic [HP_W-1:0] hp
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            last <= '0;
            hp   <= '0;
        end else if (clear) begin
            cnt  <= '0;
            last <= '0;
            hp   <= '0;
        end else if (add) begin
            cnt  <= cnt + 3'd1;
            last <= card;
            hp   <= hp + card_hp(card);
        end
    end

endmodule

// File: rtl/card_game_ctrl.sv
// Ten-and-a-half game engine: FSM, seat pointer, card handshake, settlement and win counters.
// Optional DEALER_AUTO_EN: dealer draws automatically below DEALER_STAND_HP instead of using buttons.
module card_game_ctrl
    import card_game_pkg::*;
#(
    parameter int NUM_SEATS  = 4,
    parameter int MAX_CARDS  = 5,
    parameter int NUM_ROUNDS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       hit,
    input  logic                       stand,
    card_game_if.master                cif,
    output logic [2:0]                 cur_seat,
    output logic [2:0]                 cur_cnt,
    output logic [3:0]                 cur_card,
    output logic [HP_W-1:0]            cur_hp,
    output logic [HP_W-1:0]            dealer_hp,
    output logic [NUM_SEATS-2:0]       win_mask,
    output logic [4*(NUM_SEATS-1)-1:0] wins,
    output logic [3:0]                 round,
    output logic [2:0]                 state,
    output logic                       game_over
);

    localparam int         NP     = NUM_SEATS - 1;
    localparam logic [2:0] DEALER = 3'(NUM_SEATS - 1);
    localparam logic [2:0] MAX_C  = 3'(MAX_CARDS);
    localparam logic [3:0] LAST_R = 4'(NUM_ROUNDS);

    state_t                st_q, st_d;
    logic [2:0]            seat_q, seat_d;
    logic                  dealing_q, dealing_d;
    logic [3:0]            round_q, round_d;
    logic [NP-1:0]         win_mask_q, mask_d;
    logic [NP-1:0][3:0]    wins_q;
    logic                  clear_all, do_settle, accept;
    logic                  is_dealer, turn_end, turn_hit, bust, full;
    logic [NUM_SEATS-1:0]  add_vec;
    logic [2:0]            cnt_a  [NUM_SEATS];
    logic [3:0]            last_a [NUM_SEATS];
    logic [HP_W-1:0]       hp_a   [NUM_SEATS];

    for (genvar k = 0; k < NUM_SEATS; k++) begin : g_seat
        hand_accum u_hand (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (clear_all),
            .add   (add_vec[k]),
            .card  (cif.card_num),
            .cnt   (cnt_a[k]),
            .last  (last_a[k]),
            .hp    (hp_a[k])
        );
    end

    assign cif.card_req = (st_q == WAIT_CARD);
    assign accept       = cif.card_req && cif.card_vld;
    assign is_dealer    = (seat_q == DEALER);

    always_comb begin
        cur_cnt  = '0;
        cur_card = '0;
        cur_hp   = '0;
        add_vec  = '0;
        for (int k = 0; k < NUM_SEATS; k++) begin
            add_vec[k] = accept && (seat_q == 3'(k));
            if (seat_q == 3'(k)) begin
                cur_cnt  = cnt_a[k];
                cur_card = last_a[k];
                cur_hp   = hp_a[k];
            end
        end
    end

    assign bust = (cur_hp > BUST_HP);
    assign full = (cur_cnt >= MAX_C);

    always_comb begin
`ifdef DEALER_AUTO_EN
        if (is_dealer) begin
            turn_end = bust || full || (cur_hp >= DEALER_STAND_HP);
            turn_hit = 1'b1;
        end else begin
            turn_end = stand || bust || full;
            turn_hit = hit;
        end
`else
        turn_end = stand || bust || full;
        turn_hit = hit;
`endif
    end

    // Ties and player busts go to the dealer.
    always_comb begin
        mask_d = '0;
        for (int k = 0; k < NP; k++)
            mask_d[k] = (hp_a[k] <= BUST_HP) &&
                        ((hp_a[NUM_SEATS-1] > BUST_HP) || (hp_a[k] > hp_a[NUM_SEATS-1]));
    end

    always_comb begin
        st_d      = st_q;
        seat_d    = seat_q;
        dealing_d = dealing_q;
        round_d   = round_q;
        clear_all = 1'b0;
        do_settle = 1'b0;
        case (st_q)
            IDLE: if (start) begin
                st_d      = DEAL;
                seat_d    = '0;
                dealing_d = 1'b1;
            end
            DEAL: st_d = WAIT_CARD;
            TURN: begin
                if (turn_end) begin
                    if (is_dealer) st_d = SETTLE;
                    else           seat_d = seat_q + 3'd1;
                end else if (turn_hit) begin
                    st_d = WAIT_CARD;
                end
            end
            WAIT_CARD: if (cif.card_vld) begin
                if (!dealing_q) begin
                    st_d = TURN;
                end else if (is_dealer) begin
                    st_d      = TURN;
                    seat_d    = '0;
                    dealing_d = 1'b0;
                end else begin
                    st_d   = DEAL;
                    seat_d = seat_q + 3'd1;
                end
            end
            SETTLE: begin
                do_settle = 1'b1;
                st_d      = SHOW;
            end
            SHOW: if (stand) begin
                if (round_q == LAST_R) begin
                    st_d = DONE;
                end else begin
                    st_d      = IDLE;
                    round_d   = round_q + 4'd1;
                    seat_d    = '0;
                    clear_all = 1'b1;
                end
            end
            DONE:    st_d = DONE;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= IDLE;
            seat_q     <= '0;
            dealing_q  <= 1'b0;
            round_q    <= 4'd1;
            win_mask_q <= '0;
            wins_q     <= '0;
        end else begin
            st_q      <= st_d;
            seat_q    <= seat_d;
            dealing_q <= dealing_d;
            round_q   <= round_d;
            if (do_settle) begin
                win_mask_q <= mask_d;
                for (int k = 0; k < NP; k++)
                    if (mask_d[k] && wins_q[k] != 4'd15) wins_q[k] <= wins_q[k] + 4'd1;
            end else if (clear_all) begin
                win_mask_q <= '0;
            end
        end
    end

    assign cur_seat  = seat_q;
    assign dealer_hp = hp_a[NUM_SEATS-1];
    assign win_mask  = win_mask_q;
    assign wins      = wins_q;
    assign round     = round_q;
    assign state     = st_q;
    assign game_over = (st_q == DONE);

endmodule

// File: tb/tb_card_game_ctrl.sv
// Bench for card_game_ctrl (two seats): scripted and random rounds against a card-list score model.
module tb_card_game_ctrl;

  localparam int NS = 2;
  localparam int NP = NS - 1;
  localparam int MAXC = 5;
  localparam int NR = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_DEAL = 3'd1, S_TURN = 3'd2, S_WAIT = 3'd3,
                         S_SETTLE = 3'd4, S_SHOW = 3'd5, S_DONE = 3'd6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, hit = 1'b0, stand = 1'b0;
  logic [2:0] cur_seat, cur_cnt, state;
  logic [3:0] cur_card, round;
  logic [5:0] cur_hp, dealer_hp;
  logic [NP-1:0] win_mask;
  logic [4*NP-1:0] wins;
  logic game_over;

  card_game_if cif ();

  card_game_ctrl #(.NUM_SEATS(NS), .MAX_CARDS(MAXC), .NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .stand(stand), .cif(cif),
    .cur_seat(cur_seat), .cur_cnt(cur_cnt), .cur_card(cur_card), .cur_hp(cur_hp),
    .dealer_hp(dealer_hp), .win_mask(win_mask), .wins(wins), .round(round),
    .state(state), .game_over(game_over)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad = 0;

  // reference model: score of each hand, card counts, game progress
  int m_hp[NS];
  int m_cnt[NS];
  int m_last[NS];
  int m_wins = 0;
  int m_round = 1;
  logic [NP-1:0] exp_q[$];
  int pc[$];
  int dc[$];
  logic both_once = 1'b0;
  logic stall_req = 1'b0;

  function automatic int hp_of(input int c);
    return (c >= 1 && c <= 10) ? 2 * c : 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_wins = 0;
    m_round = 1;
    exp_q.delete();
  endtask

  // driver: wait for card_req and hand one card over
  task automatic give_card(input int seat, input int v);
    int n;
    logic [31:0] vv;
    n = 0;
    while (cif.card_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (cif.card_req !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL card_req_timeout got=%b exp=1", cif.card_req);
      return;
    end
    vv = v;
    cif.card_vld = 1'b1;
    cif.card_num = vv[3:0];
    tick();
    cif.card_vld = 1'b0;
    cif.card_num = 4'($urandom_range(0, 15));
    m_hp[seat] += hp_of(v);
    m_cnt[seat]++;
    m_last[seat] = v;
  endtask

  task automatic check_turn_view(input int seat);
    total++;
    if (cur_hp !== 6'(m_hp[seat]) || cur_cnt !== 3'(m_cnt[seat]) || cur_card !== 4'(m_last[seat])) begin
      bad++;
      $display("FAIL turn_view seat=%0d got hp=%0d cnt=%0d card=%0d exp hp=%0d cnt=%0d card=%0d",
               seat, cur_hp, cur_cnt, cur_card, m_hp[seat], m_cnt[seat], m_last[seat]);
    end
  endtask

  task automatic play_player();
    int v;
    while (1) begin
      if (m_hp[0] > 21 || m_cnt[0] >= MAXC) begin
        tick();
        break;
      end
      if (pc.size() > 0) begin
        hit = 1'b1;
        tick();
        hit = 1'b0;
        total++;
        if (cif.card_req !== 1'b1 || state !== S_WAIT) begin
          bad++;
          $display("FAIL hit_latency got req=%b state=%0d exp req=1 state=%0d", cif.card_req, state, S_WAIT);
        end
        if (stall_req) begin
          stall_req = 1'b0;
          for (int i = 0; i < 10; i++) begin
            hit = (i % 2 == 0);
            tick();
            total++;
            if (cif.card_req !== 1'b1 || cur_cnt !== 3'(m_cnt[0])) begin
              bad++;
              $display("FAIL stall_hold got req=%b cnt=%0d exp req=1 cnt=%0d", cif.card_req, cur_cnt, m_cnt[0]);
            end
          end
          hit = 1'b0;
        end
        v = pc.pop_front();
        give_card(0, v);
        check_turn_view(0);
      end else begin
        stand = 1'b1;
        if (both_once) hit = 1'b1;
        tick();
        stand = 1'b0;
        hit = 1'b0;
        both_once = 1'b0;
        break;
      end
    end
    total++;
    if (cur_seat !== 3'd1 || state !== S_TURN) begin
      bad++;
      $display("FAIL seat_advance got seat=%0d state=%0d exp seat=1 state=%0d", cur_seat, state, S_TURN);
    end
  endtask

  task automatic play_dealer();
    int v;
`ifdef DEALER_AUTO_EN
    while (!(m_hp[1] > 21 || m_cnt[1] >= MAXC || m_hp[1] >= 14)) begin
      v = (dc.size() > 0) ? dc.pop_front() : int'($urandom_range(1, 13));
      give_card(1, v);
      check_turn_view(1);
    end
    tick();
`else
    while (1) begin
      if (m_hp[1] > 21 || m_cnt[1] >= MAXC) begin
        tick();
        break;
      end
      if (dc.size() > 0) begin
        hit = 1'b1;
        tick();
        hit = 1'b0;
        v = dc.pop_front();
        give_card(1, v);
        check_turn_view(1);
      end else begin
        stand = 1'b1;
        tick();
        stand = 1'b0;
        break;
      end
    end
`endif
    total++;
    if (state !== S_SETTLE) begin
      bad++;
      $display("FAIL settle_entry got=%0d exp=%0d", state, S_SETTLE);
    end
  endtask

  // one full round: deal from pc/dc fronts, turns, settlement, leave SHOW
  task automatic run_round();
    int v;
    logic [NP-1:0] e;
    for (int s = 0; s < NS; s++) begin
      m_hp[s] = 0;
      m_cnt[s] = 0;
      m_last[s] = 0;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (state !== S_DEAL) begin
      bad++;
      $display("FAIL deal_entry got=%0d exp=%0d", state, S_DEAL);
    end
    v = pc.pop_front();
    give_card(0, v);
    v = dc.pop_front();
    give_card(1, v);
    total++;
    if (state !== S_TURN || cur_seat !== 3'd0 || cur_hp !== 6'(m_hp[0]) || dealer_hp !== 6'(m_hp[1])) begin
      bad++;
      $display("FAIL deal_done got state=%0d seat=%0d hp=%0d dhp=%0d exp state=%0d seat=0 hp=%0d dhp=%0d",
               state, cur_seat, cur_hp, dealer_hp, S_TURN, m_hp[0], m_hp[1]);
    end
    play_player();
    play_dealer();
    tick();
    e = (m_hp[0] <= 21 && (m_hp[1] > 21 || m_hp[0] > m_hp[1])) ? 1'b1 : 1'b0;
    exp_q.push_back(e);
    if (e[0] && m_wins < 15) m_wins++;
    total++;
    if (state !== S_SHOW) begin
      bad++;
      $display("FAIL show_entry got=%0d exp=%0d", state, S_SHOW);
    end
    e = exp_q.pop_front();
    total++;
    if (win_mask !== e) begin
      bad++;
      $display("FAIL win_mask got=%b exp=%b (p=%0d d=%0d)", win_mask, e, m_hp[0], m_hp[1]);
    end
    total++;
    if (wins !== 4'(m_wins) || round !== 4'(m_round)) begin
      bad++;
      $display("FAIL wins_round got wins=%0d round=%0d exp wins=%0d round=%0d", wins, round, m_wins, m_round);
    end
    stand = 1'b1;
    tick();
    stand = 1'b0;
    if (m_round == NR) begin
      total++;
      if (state !== S_DONE || game_over !== 1'b1) begin
        bad++;
        $display("FAIL done_entry got state=%0d go=%b exp state=%0d go=1", state, game_over, S_DONE);
      end
    end else begin
      m_round++;
      total++;
      if (state !== S_IDLE || round !== 4'(m_round) || win_mask !== '0 || cur_hp !== 6'd0 ||
          dealer_hp !== 6'd0 || cur_cnt !== 3'd0 || cur_card !== 4'd0) begin
        bad++;
        $display("FAIL show_exit got state=%0d round=%0d wm=%b hp=%0d dhp=%0d cnt=%0d exp state=0 round=%0d clear",
                 state, round, win_mask, cur_hp, dealer_hp, cur_cnt, m_round);
      end
    end
  endtask

  task automatic test_reset();
    total++;
    if (state !== S_IDLE || cif.card_req !== 1'b0 || cur_seat !== 3'd0 || cur_cnt !== 3'd0 ||
        cur_card !== 4'd0 || cur_hp !== 6'd0 || dealer_hp !== 6'd0) begin
      bad++;
      $display("FAIL reset_hand got state=%0d req=%b seat=%0d cnt=%0d card=%0d hp=%0d dhp=%0d exp all 0",
               state, cif.card_req, cur_seat, cur_cnt, cur_card, cur_hp, dealer_hp);
    end
    total++;
    if (win_mask !== '0 || wins !== '0 || round !== 4'd1 || game_over !== 1'b0) begin
      bad++;
      $display("FAIL reset_game got wm=%b wins=%0d round=%0d go=%b exp 0 0 1 0", win_mask, wins, round, game_over);
    end
  endtask

  task automatic test_idle_ignore();
    cif.card_vld = 1'b1;
    cif.card_num = 4'd7;
    hit = 1'b1;
    stand = 1'b1;
    repeat (3) tick();
    cif.card_vld = 1'b0;
    hit = 1'b0;
    stand = 1'b0;
    total++;
    if (state !== S_IDLE || cif.card_req !== 1'b0 || cur_cnt !== 3'd0 || dealer_hp !== 6'd0) begin
      bad++;
      $display("FAIL idle_ignore got state=%0d req=%b cnt=%0d dhp=%0d exp 0 0 0 0", state, cif.card_req, cur_cnt, dealer_hp);
    end
  endtask

  task automatic test_round_bust();
    pc = '{3, 10};
    dc = '{12};
    run_round();
  endtask

  task automatic test_round_tie();
    pc = '{9, 13};
    dc = '{9, 13};
    both_once = 1'b1;
    run_round();
  endtask

  task automatic test_round_max_cards();
    pc = '{1, 1, 1, 1, 1, 1};
    dc = '{2};
    run_round();
  endtask

  task automatic test_round_stall();
    pc = '{int'($urandom_range(1, 5)), int'($urandom_range(1, 13))};
    dc = '{int'($urandom_range(1, 13))};
    stall_req = 1'b1;
    run_round();
  endtask

  task automatic test_done();
    start = 1'b1;
    tick();
    start = 1'b0;
    stand = 1'b1;
    hit = 1'b1;
    tick();
    stand = 1'b0;
    hit = 1'b0;
    total++;
    if (state !== S_DONE || game_over !== 1'b1 || cif.card_req !== 1'b0) begin
      bad++;
      $display("FAIL done_sticky got state=%0d go=%b req=%b exp state=%0d go=1 req=0", state, game_over, cif.card_req, S_DONE);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    model_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (cif.card_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (cif.card_req !== 1'b0 || state !== S_IDLE) begin
      bad++;
      $display("FAIL reset_mid got req=%b state=%0d exp req=0 state=0", cif.card_req, state);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    total++;
    if (round !== 4'd1 || wins !== '0 || cur_cnt !== 3'd0 || dealer_hp !== 6'd0) begin
      bad++;
      $display("FAIL reset_mid_clear got round=%0d wins=%0d cnt=%0d dhp=%0d exp 1 0 0 0", round, wins, cur_cnt, dealer_hp);
    end
  endtask

  task automatic test_random_games();
    for (int g = 0; g < 3; g++) begin
      for (int r = 0; r < NR; r++) begin
        pc.delete();
        dc.delete();
        repeat ($urandom_range(1, 5)) pc.push_back($urandom_range(0, 15));
        repeat ($urandom_range(1, 4)) dc.push_back($urandom_range(0, 15));
        run_round();
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      model_reset();
    end
  endtask

  initial begin
    cif.card_vld = 1'b0;
    cif.card_num = 4'd0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_idle_ignore();
    test_round_bust();
    test_round_tie();
    test_round_max_cards();
    test_round_stall();
    test_done();
    test_reset_mid();
    test_random_games();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
